bcd_serial_adder: RTL and testbench

//  Multi-digit packed-BCD adder that processes one decimal digit per clock, least significant digit first.

---
 rtl/bcd_pkg.sv | 15 +
 rtl/bcd_digit_adder.sv | 27 ++
 rtl/bcd_serial_adder.sv | 131 +++++++++++++
 tb/tb_bcd_serial_adder.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the serial packed-BCD adder.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX  = 4'd9;
  localparam bcd_digit_t BCD_CORR = 4'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_digit_adder.sv
// Single-digit BCD adder with decimal correction; flags operands above 9.
module bcd_digit_adder
  import bcd_pkg::*;
(
  input  bcd_digit_t a_d,
  input  bcd_digit_t b_d,
  input  logic       ci,
  output bcd_digit_t s_d,
  output logic       co,
  output logic       invalid
);

  logic [4:0] raw;

  // Binary sum, then +6 correction (mod 16) whenever the raw sum exceeds 9
  always_comb begin
    raw     = 5'(a_d) + 5'(b_d) + 5'(ci);
    s_d     = raw[3:0];
    co      = 1'b0;
    if (raw > 5'(BCD_MAX)) begin
      s_d = raw[3:0] + BCD_CORR;
      co  = 1'b1;
    end
    invalid = (a_d > BCD_MAX) || (b_d > BCD_MAX);
  end

endmodule

// File: rtl/bcd_serial_adder.sv
// Multi-digit packed-BCD adder, one digit per clock, least significant first.
// Optional nine's-complement subtraction when BCD_SUB_EN is defined.
module bcd_serial_adder
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                cin,
  input  logic                op,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] sum,
  output logic                cout,
  output logic                err
);

  localparam int unsigned W     = 4 * DIGITS;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  state_t           state;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic             carry_q;
  logic [IDX_W-1:0] idx;

  bcd_digit_t a_dig;
  bcd_digit_t b_dig;
  bcd_digit_t b_eff;
  bcd_digit_t s_dig;
  logic       co;
  logic       inv;

`ifdef BCD_SUB_EN
  logic op_q;
`else
  logic unused_op;
  assign unused_op = op;
`endif

  // Select the current digit of each latched operand
  always_comb begin
    a_dig = bcd_digit_t'(a_q >> {idx, 2'b00});
    b_dig = bcd_digit_t'(b_q >> {idx, 2'b00});
`ifdef BCD_SUB_EN
    // 9-B keeps invalid digits invalid (10..15 map to 15..10), so err still sees them
    b_eff = op_q ? (BCD_MAX - b_dig) : b_dig;
`else
    b_eff = b_dig;
`endif
  end

  bcd_digit_adder u_digit (
    .a_d     (a_dig),
    .b_d     (b_eff),
    .ci      (carry_q),
    .s_d     (s_dig),
    .co      (co),
    .invalid (inv)
  );

  // Control FSM, operand/result registers and handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      err       <= 1'b0;
      idx       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      carry_q   <= 1'b0;
`ifdef BCD_SUB_EN
      op_q      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= b;
`ifdef BCD_SUB_EN
            op_q     <= op;
            carry_q  <= op ? 1'b1 : cin;
`else
            carry_q  <= cin;
`endif
            err      <= 1'b0;
            sum      <= '0;
            idx      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          sum[{idx, 2'b00} +: 4] <= s_dig;
          carry_q <= co;
          err     <= err | inv;
          if (idx == LAST_IDX) begin
            cout      <= co;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Directed testbench for bcd_serial_adder (DIGITS=4), honours BCD_SUB_EN.
module tb_bcd_serial_adder;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         err;

  int n_cmp = 0;
  int n_err = 0;

  bcd_serial_adder #(.DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present operands, let one edge accept them, then scramble the inputs
  task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic ci, input logic o);
    int cyc = 0;
    while (in_ready !== 1'b1 && cyc < 50) begin
      step();
      cyc++;
    end
    if (in_ready !== 1'b1) check("in_ready_timeout", 32'(in_ready), 32'd1);
    a = av; b = bv; cin = ci; op = o; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    a = 16'h9999; b = 16'h9999; cin = ~ci; op = ~o;
  endtask

  task automatic wait_result(output int cyc);
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 50) begin
      step();
      cyc++;
    end
  endtask

  task automatic finish_op(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_ov_drop"}, 32'(out_valid), 32'd0);
    check({tag, "_ir_back"}, 32'(in_ready), 32'd1);
  endtask

  task automatic run(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                     input logic ci, input logic o,
                     input logic [W-1:0] es, input logic ec, input logic ee);
    int lat;
    start_op(av, bv, ci, o);
    wait_result(lat);
    check({tag, "_lat"},  32'(lat),  32'(DIGITS));
    check({tag, "_sum"},  32'(sum),  32'(es));
    check({tag, "_cout"}, 32'(cout), 32'(ec));
    check({tag, "_err"},  32'(err),  32'(ee));
    finish_op(tag);
  endtask

  initial begin
    int lat;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; op = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum",       32'(sum),       32'd0);
    rst_n = 1'b1;
    step();

    run("add_6_9",     16'h0006, 16'h0009, 1'b0, 1'b0, 16'h0015, 1'b0, 1'b0);
    run("ripple_9999", 16'h9999, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    run("add_9_9_c",   16'h0009, 16'h0009, 1'b1, 1'b0, 16'h0019, 1'b0, 1'b0);
    run("ripple_0001", 16'h9999, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run("add_mixed",   16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    run("invalid_c",   16'h000C, 16'h0001, 1'b0, 1'b0, 16'h0013, 1'b0, 1'b1);
    run("err_clear",   16'h0002, 16'h0003, 1'b0, 1'b0, 16'h0005, 1'b0, 1'b0);

    // Backpressure: result must hold while new requests are ignored
    start_op(16'h4567, 16'h5678, 1'b0, 1'b0);
    wait_result(lat);
    check("bp_lat", 32'(lat), 32'(DIGITS));
    in_valid = 1'b1; a = 16'h1111; b = 16'h1111;
    for (int i = 0; i < 10; i++) begin
      step();
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready",  32'(in_ready),  32'd0);
      check("bp_sum",       32'(sum),       32'h0245);
      check("bp_cout",      32'(cout),      32'd1);
    end
    in_valid = 1'b0;
    finish_op("bp");

`ifdef BCD_SUB_EN
    run("sub_5_3", 16'h0005, 16'h0003, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0);
    run("sub_3_5", 16'h0003, 16'h0005, 1'b1, 1'b1, 16'h9998, 1'b0, 1'b0);
`else
    run("op_ignored", 16'h0005, 16'h0003, 1'b0, 1'b1, 16'h0008, 1'b0, 1'b0);
`endif

    // Reset in the middle of RUN discards the partial result at once
    start_op(16'h1234, 16'h1111, 1'b0, 1'b0);
    step();
    step();
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready",  32'(in_ready),  32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_sum",       32'(sum),       32'd0);
    check("midrst_cout",      32'(cout),      32'd0);
    check("midrst_err",       32'(err),       32'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    step();
    run("post_rst", 16'h0006, 16'h0009, 1'b0, 1'b0, 16'h0015, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
